// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers for the decrypt core.
// The S-boxes are computed as inverse-plus-affine rather than stored as tables.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXPAND,
        S_ARK,
        S_ROUND,
        S_FINAL
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] r;
        sq = b;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] ark;
    logic [127:0] mc;

    always_comb begin
        sb  = '0;
        mc  = '0;
        sr  = inv_shift_rows(state_i);
        for (int i = 0; i < 16; i++)
            sb[127 - 8*i -: 8] = inv_sbox(sr[127 - 8*i -: 8]);
        ark = sb ^ rk_i;
        for (int c = 0; c < 4; c++)
            mc[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
        state_o = last_i ? ark : mc;
    end

endmodule

// File: rtl/aes_dec_core.sv
// AES-128 iterative decrypt core; walks the key schedule backwards from a cached round-10 key.
//   state    | meaning
//   S_IDLE   | waiting for load_i; key compare decides EXPAND or ARK
//   S_EXPAND | forward schedule, 10 cycles, to recover the round-10 key
//   S_ARK    | initial AddRoundKey with round-10 key
//   S_ROUND  | full inverse rounds 9..1, one per cycle
//   S_FINAL  | last inverse round with round-0 key, publish plaintext
module aes_dec_core
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic [127:0]     data_i,
    output logic [127:0]     data_o,
    output logic             busy_o,
    output logic             done_o
);

    fsm_e             fsm_r;
    logic [KEY_W-1:0] key_r;
    logic             key_vld_r;
    logic [127:0]     rk10_r;
    logic [127:0]     rk_r;
    logic [7:0]       rc_r;
    logic [3:0]       cnt_r;
    logic [3:0]       round_r;
    logic [127:0]     state_r;

    logic [127:0]     rk_next;
    logic [127:0]     rk_prev;
    logic [127:0]     round_out;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] rev_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    assign rk_next = fwd_step(rk_r, rc_r);
    assign rk_prev = rev_step(rk_r, rc_r);

    aes_inv_round u_round (
        .state_i (state_r),
        .rk_i    (rk_prev),
        .last_i  (fsm_r == S_FINAL),
        .state_o (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r     <= S_IDLE;
            key_r     <= '0;
            key_vld_r <= 1'b0;
            rk10_r    <= '0;
            rk_r      <= '0;
            rc_r      <= 8'h00;
            cnt_r     <= 4'd0;
            round_r   <= 4'd0;
            state_r   <= '0;
            data_o    <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (fsm_r)
                S_IDLE: begin
                    if (load_i) begin
                        state_r <= data_i;
                        busy_o  <= 1'b1;
                        if (key_vld_r && key_i == key_r) begin
                            fsm_r <= S_ARK;
                        end else begin
                            key_r <= key_i;
                            rk_r  <= key_i;
                            rc_r  <= 8'h01;
                            cnt_r <= 4'd0;
                            fsm_r <= S_EXPAND;
                        end
                    end
                end
                S_EXPAND: begin
                    rk_r  <= rk_next;
                    rc_r  <= xtime(rc_r);
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == 4'(NR - 1)) begin
                        rk10_r    <= rk_next;
                        key_vld_r <= 1'b1;
                        fsm_r     <= S_ARK;
                    end
                end
                S_ARK: begin
                    state_r <= state_r ^ rk10_r;
                    rk_r    <= rk10_r;
                    rc_r    <= 8'h36;
                    round_r <= 4'(NR - 1);
                    fsm_r   <= S_ROUND;
                end
                S_ROUND: begin
                    rk_r    <= rk_prev;
                    rc_r    <= inv_xtime(rc_r);
                    state_r <= round_out;
                    round_r <= round_r - 4'd1;
                    if (round_r == 4'd1) fsm_r <= S_FINAL;
                end
                S_FINAL: begin
                    data_o <= round_out;
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    fsm_r  <= S_IDLE;
                end
                default: fsm_r <= S_IDLE;
            endcase
        end
    end

endmodule
